// File: rtl/term_text_writer.sv
`default_nettype none
// ============================================================================
// Module   : term_text_writer
// Purpose  : Turns a received byte stream into character-VRAM writes for the
//            text display. It owns the cursor, line wrap, control characters,
//            and hardware scrolling through a row-offset register.
//            Optional ANSI escape parsing is enabled with the TERM_ANSI_EN
//            macro. It recognises ESC[...x and treats ESC[2J as a form feed.
// Revision : 1.0 - initial release
// ============================================================================
module term_text_writer #(
    parameter int         COLS  = 80,
    parameter int         ROWS  = 30,
    parameter int         COL_W = 7,
    parameter int         ROW_W = 5,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ROW_W+COL_W-1:0] vram_addr,
    output logic [7:0]             vram_data,
    output logic                   vram_we,
    output logic [ROW_W-1:0]       scroll_row,
    output logic [COL_W-1:0]       cur_col,
    output logic [ROW_W-1:0]       cur_row
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLR_LINE = 3'd1,
        ST_CLR_ALL  = 3'd2,
        ST_ESC      = 3'd3,
        ST_CSI      = 3'd4
    } state_t;

    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ROW_W:0]   c_ROWS_X   = (ROW_W+1)'(ROWS);

    state_t                   r_state,   w_state_n;
    logic [COL_W-1:0]         r_col,     w_col_n;
    logic [ROW_W-1:0]         r_row,     w_row_n;
    logic [ROW_W-1:0]         r_scroll,  w_scroll_n;
    logic [ROW_W+COL_W-1:0]   r_addr,    w_addr_n;
    logic [7:0]               r_data,    w_data_n;
    logic                     r_we,      w_we_n;
    logic [COL_W-1:0]         r_clr_col, w_clr_col_n;
    logic [ROW_W-1:0]         r_clr_row, w_clr_row_n;
`ifdef TERM_ANSI_EN
    logic                     r_csi_any, w_csi_any_n;   // a parameter byte was seen
    logic                     r_csi_two, w_csi_two_n;   // parameters so far are exactly "2"
`endif

    logic                     w_acc;
    logic                     w_nl;
    logic                     w_ff;
    logic [ROW_W:0]           w_sum;
    logic [ROW_W-1:0]         w_phys;
    logic [COL_W-1:0]         w_col_dec;

    // Byte acceptance: only the states that consume input are ready.
    assign in_ready = !rst && (r_state == ST_IDLE || r_state == ST_ESC ||
                               r_state == ST_CSI);
    assign w_acc    = in_valid && in_ready;

    // Logical-to-physical row. Both operands are below ROWS, so a single
    // conditional subtract implements the modulo.
    assign w_sum     = {1'b0, r_row} + {1'b0, r_scroll};
    assign w_phys    = (w_sum >= c_ROWS_X) ? ROW_W'(w_sum - c_ROWS_X) : w_sum[ROW_W-1:0];
    assign w_col_dec = r_col - COL_W'(1);

    // Next-state, cursor and VRAM-write decode.
    always_comb begin
        w_state_n   = r_state;
        w_col_n     = r_col;
        w_row_n     = r_row;
        w_scroll_n  = r_scroll;
        w_addr_n    = r_addr;
        w_data_n    = r_data;
        w_we_n      = 1'b0;
        w_clr_col_n = r_clr_col;
        w_clr_row_n = r_clr_row;
`ifdef TERM_ANSI_EN
        w_csi_any_n = r_csi_any;
        w_csi_two_n = r_csi_two;
`endif
        w_nl        = 1'b0;
        w_ff        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        w_we_n   = 1'b1;
                        w_addr_n = {w_phys, r_col};
                        w_data_n = in_data;
                        if (r_col == c_COL_LAST) begin
                            w_col_n = '0;
                            w_nl    = 1'b1;
                        end else begin
                            w_col_n = r_col + COL_W'(1);
                        end
                    end else if (in_data == 8'h0D || in_data == 8'h8D) begin
                        w_col_n = '0;
                    end else if (in_data == 8'h0A) begin
                        w_nl = 1'b1;
                    end else if (in_data == 8'h08 || in_data == 8'h7F) begin
                        if (r_col != '0) begin
                            w_col_n  = w_col_dec;
                            w_we_n   = 1'b1;
                            w_addr_n = {w_phys, w_col_dec};
                            w_data_n = BLANK;
                        end
                    end else if (in_data == 8'h0C) begin
                        w_ff = 1'b1;
`ifdef TERM_ANSI_EN
                    end else if (in_data == 8'h1B) begin
                        w_state_n = ST_ESC;
`endif
                    end
                end
            end
            ST_CLR_LINE: begin
                // The cursor already sits on the new bottom row.
                w_we_n   = 1'b1;
                w_addr_n = {w_phys, r_clr_col};
                w_data_n = BLANK;
                if (r_clr_col == c_COL_LAST) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_clr_col_n = r_clr_col + COL_W'(1);
                end
            end
            ST_CLR_ALL: begin
                w_we_n   = 1'b1;
                w_addr_n = {r_clr_row, r_clr_col};
                w_data_n = BLANK;
                if (r_clr_col == c_COL_LAST) begin
                    w_clr_col_n = '0;
                    if (r_clr_row == c_ROW_LAST) begin
                        w_state_n = ST_IDLE;
                    end else begin
                        w_clr_row_n = r_clr_row + ROW_W'(1);
                    end
                end else begin
                    w_clr_col_n = r_clr_col + COL_W'(1);
                end
            end
`ifdef TERM_ANSI_EN
            ST_ESC: begin
                if (w_acc) begin
                    w_state_n   = (in_data == 8'h5B) ? ST_CSI : ST_IDLE;
                    w_csi_any_n = 1'b0;
                    w_csi_two_n = 1'b0;
                end
            end
            ST_CSI: begin
                if (w_acc) begin
                    if (in_data >= 8'h30 && in_data <= 8'h3F) begin
                        w_csi_two_n = !r_csi_any && (in_data == 8'h32);
                        w_csi_any_n = 1'b1;
                    end else if (in_data >= 8'h40 && in_data <= 8'h7E) begin
                        w_state_n = ST_IDLE;
                        if (in_data == 8'h4A && r_csi_two) begin
                            w_ff = 1'b1;
                        end
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end
            end
`endif
            default: w_state_n = ST_IDLE;
        endcase

        if (w_nl) begin
            if (r_row != c_ROW_LAST) begin
                w_row_n = r_row + ROW_W'(1);
            end else begin
                w_scroll_n  = (r_scroll == c_ROW_LAST) ? '0 : r_scroll + ROW_W'(1);
                w_clr_col_n = '0;
                w_state_n   = ST_CLR_LINE;
            end
        end

        if (w_ff) begin
            w_col_n     = '0;
            w_row_n     = '0;
            w_scroll_n  = '0;
            w_clr_col_n = '0;
            w_clr_row_n = '0;
            w_state_n   = ST_CLR_ALL;
        end
    end

    // State, cursor and registered VRAM port; reset aborts any clear at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_scroll  <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_we      <= 1'b0;
            r_clr_col <= '0;
            r_clr_row <= '0;
`ifdef TERM_ANSI_EN
            r_csi_any <= 1'b0;
            r_csi_two <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_n;
            r_col     <= w_col_n;
            r_row     <= w_row_n;
            r_scroll  <= w_scroll_n;
            r_addr    <= w_addr_n;
            r_data    <= w_data_n;
            r_we      <= w_we_n;
            r_clr_col <= w_clr_col_n;
            r_clr_row <= w_clr_row_n;
`ifdef TERM_ANSI_EN
            r_csi_any <= w_csi_any_n;
            r_csi_two <= w_csi_two_n;
`endif
        end
    end

    assign vram_addr  = r_addr;
    assign vram_data  = r_data;
    assign vram_we    = r_we;
    assign scroll_row = r_scroll;
    assign cur_col    = r_col;
    assign cur_row    = r_row;

endmodule
`default_nettype wire

// File: tb/tb_term_text_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_term_text_writer
// Purpose  : Directed self-checking bench for term_text_writer using the
//            default 80x30 geometry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_term_text_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] vram_addr;
    logic [7:0]  vram_data;
    logic        vram_we;
    logic [4:0]  scroll_row;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] la[$];
    logic [7:0]  ld[$];

    term_text_writer dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .vram_we    (vram_we),
        .scroll_row (scroll_row),
        .cur_col    (cur_col),
        .cur_row    (cur_row)
    );

    always #5 clk = ~clk;

    // Write log sampled mid-cycle
    always @(negedge clk) begin
        if (vram_we === 1'b1) begin
            la.push_back(vram_addr);
            ld.push_back(vram_data);
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_log;
        la.delete();
        ld.delete();
    endtask

    task automatic do_reset;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        settle(2);
        rst = 1'b0;
        settle(1);
        clear_log();
    endtask

    task automatic send(input logic [7:0] b);
        int w;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 5000) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [11:0] a, input logic [7:0] d);
        logic [31:0] got;
        got = (idx < la.size()) ? {12'h0, la[idx], ld[idx]} : 32'hDEAD_BEEF;
        check(tag, got, {12'h0, a, d});
    endtask

    task automatic wait_ready;
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 5000) check("ready_timeout", 32'd0, 32'd1);
        settle(3);
    endtask

    task automatic check_full_clear(input string tag);
        int bad_ord;
        int bad_col;
        logic [11:0] ea;
        bad_ord = 0;
        bad_col = 0;
        check({tag, "_count"}, la.size(), 2400);
        for (int i = 0; i < la.size(); i++) begin
            ea = {5'(i / 80), 7'(i % 80)};
            if (la[i] !== ea || ld[i] !== 8'h20) bad_ord++;
            if (la[i][6:0] >= 7'd80) bad_col++;
        end
        check({tag, "_order"}, bad_ord, 0);
        check({tag, "_col_range"}, bad_col, 0);
    endtask

    initial begin
        int          low;
        int          bad;
        int          w;
        logic [7:0]  seq[7];

        // Reset state
        settle(2);
        check("rst_ready", in_ready, 0);
        check("rst_we", vram_we, 0);
        check("rst_addr", vram_addr, 0);
        check("rst_data", vram_data, 0);
        check("rst_scroll", scroll_row, 0);
        check("rst_col", cur_col, 0);
        check("rst_row", cur_row, 0);
        rst = 1'b0;
        settle(1);
        check("idle_ready", in_ready, 1);
        clear_log();

        // "Hi"
        send(8'h48);
        send(8'h69);
        settle(2);
        check("hi_count", la.size(), 2);
        check_wr("hi_w0", 0, 12'h000, 8'h48);
        check_wr("hi_w1", 1, 12'h001, 8'h69);
        check("hi_col", cur_col, 2);

        // 80 x 'A' wraps onto row 1 without a clear
        do_reset();
        for (int i = 0; i < 80; i++) send(8'h41);
        settle(4);
        check("wrap_count", la.size(), 80);
        bad = 0;
        for (int i = 0; i < la.size(); i++)
            if (la[i] !== 12'(i) || ld[i] !== 8'h41) bad++;
        check("wrap_data", bad, 0);
        check("wrap_col", cur_col, 0);
        check("wrap_row", cur_row, 1);
        check("wrap_ready", in_ready, 1);

        // Walk down to row 29, then CR+LF scrolls
        for (int i = 0; i < 28; i++) send(8'h0A);
        settle(2);
        check("bottom_row", cur_row, 29);
        check("bottom_scroll", scroll_row, 0);
        clear_log();
        send(8'h0D);
        send(8'h0A);
        // 'x' held on in_valid during the clear must be taken exactly once
        @(negedge clk);
        in_data  = 8'h78;
        in_valid = 1'b1;
        low = 0;
        while (!in_ready && low < 1000) begin
            low++;
            @(negedge clk);
        end
        check("scroll_busy_cycles", low, 80);
        @(posedge clk);
        #1 in_valid = 1'b0;
        settle(3);
        check("scroll_count", la.size(), 81);
        bad = 0;
        for (int i = 0; i < 80 && i < la.size(); i++)
            if (la[i] !== {5'd0, 7'(i)} || ld[i] !== 8'h20) bad++;
        check("scroll_blank", bad, 0);
        check_wr("scroll_x", 80, 12'h000, 8'h78);
        check("scroll_val", scroll_row, 1);
        check("scroll_row", cur_row, 29);
        check("scroll_col", cur_col, 1);

        // Form feed with a non-zero scroll offset
        clear_log();
        send(8'h0C);
        wait_ready();
        check_full_clear("ff");
        check("ff_col", cur_col, 0);
        check("ff_row", cur_row, 0);
        check("ff_scroll", scroll_row, 0);

        // Reset in the middle of a full clear
        clear_log();
        send(8'h0C);
        w = 0;
        while (la.size() < 100 && w < 5000) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("abort_reach100", la.size(), 100);
        check_wr("abort_w99", 99, {5'd1, 7'd19}, 8'h20);
        rst = 1'b1;
        @(negedge clk);
        check("abort_we", vram_we, 0);
        check("abort_ready_rst", in_ready, 0);
        #1 rst = 1'b0;
        settle(5);
        check("abort_no_more", la.size(), 100);
        check("abort_idle", in_ready, 1);
        check("abort_col", cur_col, 0);

        // Backspace, CR variants, dropped bytes
        clear_log();
        send(8'h61);
        send(8'h62);
        send(8'h08);
        send(8'h63);
        settle(2);
        check("bs_count", la.size(), 4);
        check_wr("bs_w0", 0, 12'h000, 8'h61);
        check_wr("bs_w1", 1, 12'h001, 8'h62);
        check_wr("bs_w2", 2, 12'h001, 8'h20);
        check_wr("bs_w3", 3, 12'h001, 8'h63);
        check("bs_col", cur_col, 2);
        send(8'h0D);
        send(8'h7F);
        settle(2);
        check("bs0_count", la.size(), 4);
        check("bs0_col", cur_col, 0);
        send(8'h71);
        send(8'h85);
        send(8'h01);
        settle(2);
        check("drop_count", la.size(), 5);
        check("drop_col", cur_col, 1);
        send(8'h8D);
        settle(2);
        check("cr8d_col", cur_col, 0);
        check("cr8d_count", la.size(), 5);

        // Escape sequence ESC[31m followed by "OK"
        do_reset();
        seq = '{8'h1B, 8'h5B, 8'h33, 8'h31, 8'h6D, 8'h4F, 8'h4B};
        for (int i = 0; i < 7; i++) send(seq[i]);
        settle(2);
`ifdef TERM_ANSI_EN
        check("esc_count", la.size(), 2);
        check_wr("esc_w0", 0, 12'h000, 8'h4F);
        check_wr("esc_w1", 1, 12'h001, 8'h4B);
        check("esc_col", cur_col, 2);
        clear_log();
        send(8'h1B);
        send(8'h5B);
        send(8'h32);
        send(8'h4A);
        wait_ready();
        check_full_clear("esc2j");
        check("esc2j_col", cur_col, 0);
`else
        check("esc_count", la.size(), 6);
        for (int i = 0; i < 6; i++)
            check_wr("esc_plain", i, 12'(i), seq[i+1]);
        check("esc_col", cur_col, 6);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
